// File: rtl/feeder_pkg.sv
// Shared types and helpers for the window feeder: FSM state encoding and
// counter width calculation.
package feeder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PRIME,
      STREAM,
      DRAIN
   } feeder_state_t;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/window_feeder_line_buffer.sv
// Single-row line buffer: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module line_buffer
   import feeder_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WIDTH = 128,
   localparam int AW   = clog2_min1(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage and read register; contents are never cleared.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: rtl/window_feeder.sv
// Transmit side of the convolution engine input: serialises one kernel onto
// weight/weight_valid and turns a raster word stream into KERNEL_HEIGHT
// vertically stacked words using a chain of KERNEL_HEIGHT-1 line buffers.
module window_feeder
   import feeder_pkg::*;
#(
   parameter int WEIGHT_WIDTH  = 8,
   parameter int IMAGE_WIDTH   = 16,
   parameter int IMAGE_NB      = 8,
   parameter int KERNEL_WIDTH  = 3,
   parameter int KERNEL_HEIGHT = 3,
   parameter int ROW_WORDS     = 32,
   localparam int WORD_WIDTH   = IMAGE_WIDTH * IMAGE_NB,
   localparam int KERNEL_NB    = KERNEL_WIDTH * KERNEL_HEIGHT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [WEIGHT_WIDTH*KERNEL_NB-1:0]   kernel_in,
   input  logic                                kernel_valid,
   output logic                                kernel_ready,
   input  logic [WORD_WIDTH-1:0]               up_data,
   input  logic                                up_last,
   input  logic                                up_valid,
   output logic                                up_ready,
   output logic [WEIGHT_WIDTH-1:0]             weight,
   output logic                                weight_valid,
   output logic [WORD_WIDTH*KERNEL_HEIGHT-1:0] image,
   output logic                                image_valid,
   output logic                                frame_err
);

   localparam int COL_W  = clog2_min1(ROW_WORDS);
   localparam int ROW_W  = clog2_min1(KERNEL_HEIGHT);
   localparam int WCNT_W = clog2_min1(KERNEL_NB);
   localparam int NLB    = KERNEL_HEIGHT - 1;

   feeder_state_t state;

   logic [COL_W-1:0]                  col;
   logic [COL_W-1:0]                  col_inc;
   logic                              col_wrap;
   logic [ROW_W-1:0]                  row;
   logic [WCNT_W-1:0]                 wcnt;
   logic [WCNT_W-1:0]                 wcnt_nxt;
   logic                              drain_cnt;
   logic [WEIGHT_WIDTH*KERNEL_NB-1:0] kernel_reg;

   logic                              up_fire;
   logic                              kernel_fire;

   logic                              vld_p1;
   logic                              img_p1;
   logic [WORD_WIDTH-1:0]             word_p1;
   logic [COL_W-1:0]                  col_p1;

   logic [WORD_WIDTH-1:0]             lb_rdata [NLB];
   logic [WORD_WIDTH-1:0]             lb_wdata [NLB];
   logic [WORD_WIDTH*KERNEL_HEIGHT-1:0] image_nxt;

   assign up_fire     = up_valid & up_ready;
   assign kernel_fire = kernel_valid & kernel_ready;
   assign col_wrap    = (col == COL_W'(ROW_WORDS - 1));
   assign col_inc     = col_wrap ? '0 : col + COL_W'(1);
   assign wcnt_nxt    = wcnt + WCNT_W'(1);

   // Control FSM with registered handshake and weight outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         col          <= '0;
         row          <= '0;
         wcnt         <= '0;
         drain_cnt    <= 1'b0;
         kernel_ready <= 1'b0;
         up_ready     <= 1'b0;
         weight_valid <= 1'b0;
         weight       <= '0;
         frame_err    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               up_ready <= 1'b0;
               // A pending kernel blocks the image path until it is taken,
               // even in the first idle cycle when ready is still rising.
               if (kernel_valid) begin
                  if (kernel_ready) begin
                     state        <= LOAD;
                     kernel_ready <= 1'b0;
                     wcnt         <= '0;
                     weight_valid <= 1'b1;
                     weight       <= kernel_in[0 +: WEIGHT_WIDTH];
                  end else begin
                     kernel_ready <= 1'b1;
                  end
               end else if (up_valid) begin
                  state        <= PRIME;
                  kernel_ready <= 1'b0;
                  up_ready     <= 1'b1;
                  col          <= '0;
                  row          <= '0;
               end else begin
                  kernel_ready <= 1'b1;
               end
            end

            LOAD: begin
               if (wcnt == WCNT_W'(KERNEL_NB - 1)) begin
                  state        <= IDLE;
                  weight_valid <= 1'b0;
                  kernel_ready <= 1'b1;
                  wcnt         <= '0;
               end else begin
                  wcnt   <= wcnt_nxt;
                  weight <= kernel_reg[wcnt_nxt*WEIGHT_WIDTH +: WEIGHT_WIDTH];
               end
            end

            PRIME: begin
               if (up_fire) begin
                  if (up_last) begin
                     frame_err    <= 1'b1;
                     state        <= IDLE;
                     up_ready     <= 1'b0;
                     kernel_ready <= 1'b1;
                     col          <= '0;
                     row          <= '0;
                  end else begin
                     col <= col_inc;
                     if (col_wrap) begin
                        row <= row + ROW_W'(1);
                        if (row == ROW_W'(KERNEL_HEIGHT - 2)) state <= STREAM;
                     end
                  end
               end
            end

            STREAM: begin
               if (up_fire) begin
                  if (up_last) begin
                     state     <= DRAIN;
                     up_ready  <= 1'b0;
                     drain_cnt <= 1'b0;
                     col       <= '0;
                     row       <= '0;
                  end else begin
                     col <= col_inc;
                  end
               end
            end

            DRAIN: begin
               // Two idle cycles let the last word clear the read and output registers.
               if (drain_cnt) begin
                  state        <= IDLE;
                  kernel_ready <= 1'b1;
                  drain_cnt    <= 1'b0;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Kernel capture on handshake; LOAD walks through it one slot per cycle.
   always_ff @(posedge clk) begin
      if (kernel_fire) kernel_reg <= kernel_in;
   end

   // Stage p1 control: accepted-word flag and whether it produces a window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         img_p1 <= 1'b0;
      end else begin
         vld_p1 <= up_fire;
         img_p1 <= up_fire && (state == STREAM);
      end
   end

   // Stage p1 data: word and column travel alongside the RAM read.
   always_ff @(posedge clk) begin
      if (up_fire) begin
         word_p1 <= up_data;
         col_p1  <= col;
      end
   end

   // Buffer 0 holds the previous row; each older buffer takes the row that
   // was just read out of its younger neighbour, written back one cycle
   // after the read at the same column.
   for (genvar i = 0; i < NLB; i++) begin : g_lb
      if (i == 0) begin : g_head
         assign lb_wdata[i] = word_p1;
      end else begin : g_chain
         assign lb_wdata[i] = lb_rdata[i-1];
      end

      line_buffer #(
         .DEPTH (ROW_WORDS),
         .WIDTH (WORD_WIDTH)
      ) u_lb (
         .clk   (clk),
         .we    (vld_p1),
         .waddr (col_p1),
         .wdata (lb_wdata[i]),
         .re    (up_fire),
         .raddr (col),
         .rdata (lb_rdata[i])
      );
   end

   // Window assembly: oldest row in slot 0, current word in the top slot.
   always_comb begin
      image_nxt = '0;
      image_nxt[(KERNEL_HEIGHT-1)*WORD_WIDTH +: WORD_WIDTH] = word_p1;
      for (int j = 0; j < NLB; j++) begin
         image_nxt[j*WORD_WIDTH +: WORD_WIDTH] = lb_rdata[NLB-1-j];
      end
   end

   // Stage p2: output register, holds the last window while invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         image_valid <= 1'b0;
         image       <= '0;
      end else begin
         image_valid <= img_p1;
         if (img_p1) image <= image_nxt;
      end
   end

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder with a 3x3 kernel and 4-word rows.
module tb_window_feeder;

   localparam int WW   = 8;
   localparam int IW   = 16;
   localparam int NB   = 8;
   localparam int KW   = 3;
   localparam int KH   = 3;
   localparam int RW   = 4;
   localparam int WORD = IW * NB;
   localparam int KNB  = KW * KH;
   localparam int CW   = WORD * KH;

   logic              clk;
   logic              rst;
   logic [WW*KNB-1:0] kernel_in;
   logic              kernel_valid;
   logic              kernel_ready;
   logic [WORD-1:0]   up_data;
   logic              up_last;
   logic              up_valid;
   logic              up_ready;
   logic [WW-1:0]     weight;
   logic              weight_valid;
   logic [CW-1:0]     image;
   logic              image_valid;
   logic              frame_err;

   int total = 0;
   int bad   = 0;

   window_feeder #(
      .WEIGHT_WIDTH  (WW),
      .IMAGE_WIDTH   (IW),
      .IMAGE_NB      (NB),
      .KERNEL_WIDTH  (KW),
      .KERNEL_HEIGHT (KH),
      .ROW_WORDS     (RW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .kernel_in    (kernel_in),
      .kernel_valid (kernel_valid),
      .kernel_ready (kernel_ready),
      .up_data      (up_data),
      .up_last      (up_last),
      .up_valid     (up_valid),
      .up_ready     (up_ready),
      .weight       (weight),
      .weight_valid (weight_valid),
      .image        (image),
      .image_valid  (image_valid),
      .frame_err    (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       last;
      logic       ur;
      logic       iv;
      logic [7:0] e2;
      logic [7:0] e1;
      logic [7:0] e0;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic v, input int d, input logic last,
                               input logic ur, input logic iv,
                               input int e2, input int e1, input int e0);
      vec_t r;
      r.v = v; r.d = 8'(d); r.last = last; r.ur = ur; r.iv = iv;
      r.e2 = 8'(e2); r.e1 = 8'(e1); r.e0 = 8'(e0);
      return r;
   endfunction

   function automatic logic [CW-1:0] mk_img(input logic [7:0] e2, input logic [7:0] e1,
                                            input logic [7:0] e0);
      return {WORD'(e2), WORD'(e1), WORD'(e0)};
   endfunction

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_kernel(input int base);
      for (int k = 0; k < KNB; k++) kernel_in[k*WW +: WW] = 8'(base + k);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      kernel_in    = '0;
      kernel_valid = 1'b0;
      up_data      = '0;
      up_last      = 1'b0;
      up_valid     = 1'b0;

      // Rows observed just after each row's clock edge: a word shows up on
      // image one row later than the row that offered it.
      for (int i = 0; i < 9; i++) tbl[i] = mk(1, i, 0, 1, 0, 0, 0, 0);
      tbl[9]  = mk(1,  9, 0, 1, 1,  8, 4, 0);
      tbl[10] = mk(1, 10, 0, 1, 1,  9, 5, 1);
      tbl[11] = mk(1, 11, 0, 1, 1, 10, 6, 2);
      tbl[12] = mk(0,  0, 0, 1, 1, 11, 7, 3);
      tbl[13] = mk(1, 12, 0, 1, 0, 11, 7, 3);
      tbl[14] = mk(0,  0, 0, 1, 1, 12, 8, 4);
      tbl[15] = mk(1, 13, 1, 0, 0, 12, 8, 4);
      tbl[16] = mk(0,  0, 0, 0, 1, 13, 9, 5);
      tbl[17] = mk(0,  0, 0, 0, 0, 13, 9, 5);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_kernel_ready", CW'(kernel_ready), CW'(0));
      chk("rst_up_ready",     CW'(up_ready),     CW'(0));
      chk("rst_weight_valid", CW'(weight_valid), CW'(0));
      chk("rst_image_valid",  CW'(image_valid),  CW'(0));
      chk("rst_frame_err",    CW'(frame_err),    CW'(0));
      chk("rst_weight",       CW'(weight),       CW'(0));
      chk("rst_image",        image,             CW'(0));
      rst = 1'b0;
      tick();
      chk("idle_kernel_ready", CW'(kernel_ready), CW'(1));
      chk("idle_up_ready",     CW'(up_ready),     CW'(0));

      // Kernel load with up_valid also high: kernel wins
      set_kernel(1);
      kernel_valid = 1'b1;
      up_valid     = 1'b1;
      tick();
      kernel_valid = 1'b0;
      for (int i = 0; i < KNB; i++) begin
         chk($sformatf("load_wv_%0d", i), CW'(weight_valid), CW'(1));
         chk($sformatf("load_w_%0d", i),  CW'(weight),       CW'(i + 1));
         chk($sformatf("load_ur_%0d", i), CW'(up_ready),     CW'(0));
         chk($sformatf("load_kr_%0d", i), CW'(kernel_ready), CW'(0));
         tick();
      end
      chk("load_end_wv", CW'(weight_valid), CW'(0));
      chk("load_end_kr", CW'(kernel_ready), CW'(1));
      chk("load_end_ur", CW'(up_ready),     CW'(0));
      up_valid = 1'b0;
      tick();

      // Short frame: up_last on word 5 while priming
      up_valid = 1'b1;
      up_data  = '0;
      tick();
      chk("short_ur", CW'(up_ready), CW'(1));
      for (int i = 0; i < 6; i++) begin
         up_data = WORD'(i);
         up_last = (i == 5);
         tick();
         chk($sformatf("short_ferr_%0d", i), CW'(frame_err),   CW'(i == 5));
         chk($sformatf("short_iv_%0d", i),   CW'(image_valid), CW'(0));
      end
      up_valid = 1'b0;
      up_last  = 1'b0;
      tick();
      chk("short_ferr_off", CW'(frame_err),    CW'(0));
      chk("short_ur_off",   CW'(up_ready),     CW'(0));
      chk("short_kr_back",  CW'(kernel_ready), CW'(1));
      chk("short_iv_off",   CW'(image_valid),  CW'(0));

      // Full frame: priming, streaming, gaps and drain
      up_valid = 1'b1;
      up_data  = '0;
      tick();
      for (int i = 0; i < NV; i++) begin
         up_valid = tbl[i].v;
         up_data  = WORD'(tbl[i].d);
         up_last  = tbl[i].last;
         tick();
         chk($sformatf("frm_ur_%0d", i),   CW'(up_ready),    CW'(tbl[i].ur));
         chk($sformatf("frm_iv_%0d", i),   CW'(image_valid), CW'(tbl[i].iv));
         chk($sformatf("frm_img_%0d", i),  image,            mk_img(tbl[i].e2, tbl[i].e1, tbl[i].e0));
         chk($sformatf("frm_ferr_%0d", i), CW'(frame_err),   CW'(0));
      end
      up_valid = 1'b0;
      up_last  = 1'b0;
      chk("frm_idle_kr", CW'(kernel_ready), CW'(1));

      // Asynchronous reset in the middle of a kernel load
      set_kernel(1);
      kernel_valid = 1'b1;
      tick();
      kernel_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("mid_w4", CW'(weight), CW'(4));
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_wv", CW'(weight_valid), CW'(0));
      chk("mid_rst_kr", CW'(kernel_ready), CW'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_kr", CW'(kernel_ready), CW'(1));
      set_kernel(11);
      kernel_valid = 1'b1;
      tick();
      kernel_valid = 1'b0;
      chk("reload_wv", CW'(weight_valid), CW'(1));
      chk("reload_w0", CW'(weight),       CW'(11));
      tick();
      chk("reload_w1", CW'(weight),       CW'(12));
      repeat (9) tick();
      chk("reload_done_wv", CW'(weight_valid), CW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
